// File: rtl/jpeg_block_sequencer_if.sv
// Handshake and control bundle between the JPEG block sequencer (slave) and its
// surrounding datapath/upstream logic (master).
interface jpeg_block_sequencer_if;
  logic        blk_valid;
  logic        blk_ready;
  logic        frame_start;
  logic        huff_done;
  logic        input_enable;
  logic        dct_enable;
  logic        dct_end_enable;
  logic [7:0]  matrix_row;
  logic        zigzag_input_enable;
  logic        zigag_enable;
  logic        Huffman_start;
  logic        is_luminance;
  logic        busy;
  logic [15:0] blk_count;
  logic        error;

  modport master (
    output blk_valid, frame_start, huff_done,
    input  blk_ready, input_enable, dct_enable, dct_end_enable, matrix_row,
           zigzag_input_enable, zigag_enable, Huffman_start, is_luminance,
           busy, blk_count, error
  );

  modport slave (
    input  blk_valid, frame_start, huff_done,
    output blk_ready, input_enable, dct_enable, dct_end_enable, matrix_row,
           zigzag_input_enable, zigag_enable, Huffman_start, is_luminance,
           busy, blk_count, error
  );
endinterface

// File: rtl/jpeg_block_sequencer.sv
// Per-8x8-block control FSM for the JPEG encoder datapath.
// Optional Huffman watchdog enabled by defining JPEG_SEQ_WDOG_EN.
module jpeg_block_sequencer #(
  parameter int DCT_LATENCY   = 8,
  parameter int QUANT_LATENCY = 1,
  parameter int LUMA_BLOCKS   = 4,
  parameter int CHROMA_BLOCKS = 2,
  parameter int HUFF_TIMEOUT  = 4095
) (
  input logic                  clock,
  input logic                  reset,
  jpeg_block_sequencer_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, LOAD, DCT_GO, DCT_WAIT, DCT_STORE, QUANT, ZIGZAG, HUFF_GO, HUFF_WAIT, DONE
  } state_t;

  state_t      state;
  logic        blk_ready;
  logic        input_enable;
  logic        dct_enable;
  logic        dct_end_enable;
  logic [7:0]  matrix_row;
  logic        zigzag_input_enable;
  logic        zigag_enable;
  logic        huffman_start;
  logic        is_luminance;
  logic        busy;
  logic [15:0] blk_count;
  logic [15:0] dct_cnt;
  logic [7:0]  hold_cnt;
  logic [4:0]  comp_idx;
  logic        frame_pending;
`ifdef JPEG_SEQ_WDOG_EN
  logic [15:0] wd_cnt;
  logic        error_flag;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state               <= IDLE;
      blk_ready           <= 1'b0;
      input_enable        <= 1'b0;
      dct_enable          <= 1'b0;
      dct_end_enable      <= 1'b0;
      matrix_row          <= 8'd0;
      zigzag_input_enable <= 1'b0;
      zigag_enable        <= 1'b0;
      huffman_start       <= 1'b0;
      is_luminance        <= 1'b0;
      busy                <= 1'b0;
      blk_count           <= 16'd0;
      dct_cnt             <= 16'd0;
      hold_cnt            <= 8'd0;
      comp_idx            <= 5'd0;
      frame_pending       <= 1'b0;
`ifdef JPEG_SEQ_WDOG_EN
      wd_cnt              <= 16'd0;
      error_flag          <= 1'b0;
`endif
    end else begin
      input_enable        <= 1'b0;
      dct_enable          <= 1'b0;
      dct_end_enable      <= 1'b0;
      zigzag_input_enable <= 1'b0;
      zigag_enable        <= 1'b0;
      huffman_start       <= 1'b0;
      // A frame restart seen mid-block is deferred to DONE so the current block keeps its table set.
      if (state != IDLE && bus.frame_start)
        frame_pending <= 1'b1;

      case (state)
        IDLE: begin
          blk_ready <= 1'b1;
          if (bus.frame_start)
            comp_idx <= 5'd0;
          if (bus.blk_valid && blk_ready) begin
            state        <= LOAD;
            blk_ready    <= 1'b0;
            busy         <= 1'b1;
            input_enable <= 1'b1;
            is_luminance <= bus.frame_start || (comp_idx < 5'(LUMA_BLOCKS));
          end
        end
        LOAD: begin
          state      <= DCT_GO;
          dct_enable <= 1'b1;
        end
        DCT_GO: begin
          dct_cnt <= 16'd1;
          if (DCT_LATENCY == 1) begin
            state          <= DCT_STORE;
            dct_end_enable <= 1'b1;
          end else begin
            state <= DCT_WAIT;
          end
        end
        DCT_WAIT: begin
          if (dct_cnt == 16'(DCT_LATENCY - 1)) begin
            state          <= DCT_STORE;
            dct_end_enable <= 1'b1;
          end else begin
            dct_cnt <= dct_cnt + 16'd1;
          end
        end
        DCT_STORE: begin
          state               <= QUANT;
          matrix_row          <= 8'd0;
          hold_cnt            <= 8'd0;
          zigzag_input_enable <= (QUANT_LATENCY == 0);
        end
        // zigzag_input_enable is registered, so it is raised one cycle ahead of a row's last cycle.
        QUANT: begin
          if (hold_cnt == 8'(QUANT_LATENCY)) begin
            if (matrix_row == 8'd7) begin
              state        <= ZIGZAG;
              matrix_row   <= 8'd0;
              zigag_enable <= 1'b1;
            end else begin
              matrix_row          <= matrix_row + 8'd1;
              hold_cnt            <= 8'd0;
              zigzag_input_enable <= (QUANT_LATENCY == 0);
            end
          end else begin
            hold_cnt            <= hold_cnt + 8'd1;
            zigzag_input_enable <= (hold_cnt + 8'd1 == 8'(QUANT_LATENCY));
          end
        end
        ZIGZAG: begin
          state         <= HUFF_GO;
          huffman_start <= 1'b1;
        end
        HUFF_GO: begin
          state <= HUFF_WAIT;
`ifdef JPEG_SEQ_WDOG_EN
          wd_cnt <= 16'd1;
`endif
        end
        HUFF_WAIT: begin
          if (bus.huff_done) begin
            state <= DONE;
`ifdef JPEG_SEQ_WDOG_EN
          end else if (wd_cnt == 16'(HUFF_TIMEOUT)) begin
            error_flag <= 1'b1;
            state      <= DONE;
          end else begin
            wd_cnt <= wd_cnt + 16'd1;
`endif
          end
        end
        DONE: begin
          state         <= IDLE;
          busy          <= 1'b0;
          blk_ready     <= 1'b1;
          blk_count     <= blk_count + 16'd1;
          frame_pending <= 1'b0;
          if (frame_pending || bus.frame_start || comp_idx == 5'(LUMA_BLOCKS + CHROMA_BLOCKS - 1))
            comp_idx <= 5'd0;
          else
            comp_idx <= comp_idx + 5'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.blk_ready           = blk_ready;
  assign bus.input_enable        = input_enable;
  assign bus.dct_enable          = dct_enable;
  assign bus.dct_end_enable      = dct_end_enable;
  assign bus.matrix_row          = matrix_row;
  assign bus.zigzag_input_enable = zigzag_input_enable;
  assign bus.zigag_enable        = zigag_enable;
  assign bus.Huffman_start       = huffman_start;
  assign bus.is_luminance        = is_luminance;
  assign bus.busy                = busy;
  assign bus.blk_count           = blk_count;
`ifdef JPEG_SEQ_WDOG_EN
  assign bus.error               = error_flag;
`else
  assign bus.error               = 1'b0;
`endif

endmodule

// File: tb/tb_jpeg_block_sequencer.sv
// Self-checking bench for jpeg_block_sequencer: timing of every strobe is derived
// from block-relative cycle offsets and MCU order from modular arithmetic.
module tb_jpeg_block_sequencer;

  localparam int DL  = 8;
  localparam int QL  = 1;
  localparam int H   = QL + 1;
  localparam int LB  = 4;
  localparam int CB  = 2;
`ifdef JPEG_SEQ_WDOG_EN
  localparam int TO  = 20;
`else
  localparam int TO  = 4095;
`endif
  localparam int Q0  = 3 + DL;
  localparam int ZZ  = Q0 + 8 * H;
  localparam int HW0 = ZZ + 2;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  jpeg_block_sequencer_if bus();

  jpeg_block_sequencer #(
    .DCT_LATENCY(DL), .QUANT_LATENCY(QL), .LUMA_BLOCKS(LB),
    .CHROMA_BLOCKS(CB), .HUFF_TIMEOUT(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;
  int m_comp   = 0;
  int m_count  = 0;
  bit m_err    = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_reset(input string tag);
    check({tag, "_input_enable"}, 32'(bus.input_enable), 0);
    check({tag, "_dct_enable"}, 32'(bus.dct_enable), 0);
    check({tag, "_dct_end_enable"}, 32'(bus.dct_end_enable), 0);
    check({tag, "_matrix_row"}, 32'(bus.matrix_row), 0);
    check({tag, "_zigzag_input_enable"}, 32'(bus.zigzag_input_enable), 0);
    check({tag, "_zigag_enable"}, 32'(bus.zigag_enable), 0);
    check({tag, "_Huffman_start"}, 32'(bus.Huffman_start), 0);
    check({tag, "_is_luminance"}, 32'(bus.is_luminance), 0);
    check({tag, "_busy"}, 32'(bus.busy), 0);
    check({tag, "_blk_count"}, 32'(bus.blk_count), 0);
    check({tag, "_error"}, 32'(bus.error), 0);
    check({tag, "_blk_ready"}, 32'(bus.blk_ready), 0);
  endtask

  // huff_t: cycle offset of huff_done (0 = never, relies on watchdog).
  // fs_t: cycle offset of a mid-block frame_start (0 = none).
  // abort_t: cycle offset at which reset is asserted (0 = none).
  task automatic run_block(input int huff_t, input bit fs_accept, input int fs_t, input int abort_t);
    int  waited = 0;
    bit  lum;
    bit  wd;
    bit  pending = 1'b0;
    int  t_end;
    forever begin
      @(negedge clock);
      bus.blk_valid   = 1'b1;
      bus.frame_start = fs_accept;
      bus.huff_done   = 1'b0;
      if (bus.blk_ready === 1'b1) break;
      waited++;
      if (waited > 10) begin
        check("accept_timeout", 32'(bus.blk_ready), 1);
        bus.blk_valid = 1'b0;
        return;
      end
    end
    if (fs_accept) m_comp = 0;
    lum   = (m_comp < LB);
    wd    = (huff_t == 0);
    t_end = wd ? HW0 + TO - 1 : huff_t;

    for (int t = 1; t <= t_end + 2; t++) begin
      bit in_q;
      bit exp_busy;
      int exp_row;
      bit exp_zie;
      @(negedge clock);
      in_q     = (t >= Q0) && (t < Q0 + 8 * H);
      exp_row  = in_q ? (t - Q0) / H : 0;
      exp_zie  = in_q && (((t - Q0) % H) == H - 1);
      exp_busy = (t <= t_end + 1);
      check("input_enable", 32'(bus.input_enable), 32'(t == 1));
      check("dct_enable", 32'(bus.dct_enable), 32'(t == 2));
      check("dct_end_enable", 32'(bus.dct_end_enable), 32'(t == 2 + DL));
      check("matrix_row", 32'(bus.matrix_row), 32'(exp_row));
      check("zigzag_input_enable", 32'(bus.zigzag_input_enable), 32'(exp_zie));
      check("zigag_enable", 32'(bus.zigag_enable), 32'(t == ZZ));
      check("Huffman_start", 32'(bus.Huffman_start), 32'(t == ZZ + 1));
      check("busy", 32'(bus.busy), 32'(exp_busy));
      check("blk_ready", 32'(bus.blk_ready), 32'(!exp_busy));
      if (exp_busy)
        check("is_luminance", 32'(bus.is_luminance), 32'(lum));
      check("blk_count", 32'(bus.blk_count),
            32'((m_count + ((t == t_end + 2) ? 1 : 0)) & 16'hFFFF));
      check("error", 32'(bus.error), 32'(m_err || (wd && t >= t_end + 1)));

      if (abort_t != 0 && t == abort_t) begin
        reset = 1'b1;
        @(negedge clock);
        check_idle_reset("abort");
        m_count = 0;
        m_comp  = 0;
        m_err   = 1'b0;
        bus.blk_valid   = 1'b0;
        bus.huff_done   = 1'b0;
        bus.frame_start = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        check("abort_release_blk_ready", 32'(bus.blk_ready), 1);
        return;
      end

      bus.blk_valid   = exp_busy ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.huff_done   = (t == huff_t) || (t < HW0 && $urandom_range(0, 7) == 0);
      bus.frame_start = (t == fs_t) && exp_busy;
      if (t == fs_t && exp_busy) pending = 1'b1;
    end
    bus.blk_valid   = 1'b0;
    bus.huff_done   = 1'b0;
    bus.frame_start = 1'b0;
    m_count = (m_count + 1) & 16'hFFFF;
    m_comp  = pending ? 0 : (m_comp + 1) % (LB + CB);
    if (wd) m_err = 1'b1;
  endtask

  initial begin
    reset           = 1'b1;
    bus.blk_valid   = 1'b1;
    bus.huff_done   = 1'b0;
    bus.frame_start = 1'b0;
    repeat (3) @(negedge clock);
    check_idle_reset("reset");
    reset         = 1'b0;
    bus.blk_valid = 1'b0;
    @(negedge clock);
    check("release_blk_ready", 32'(bus.blk_ready), 1);
    check("release_busy", 32'(bus.busy), 0);

    // Nominal block, huff_done at T40.
    run_block(40, 1'b0, 0, 0);

    // Six more blocks complete the 7-block MCU order sweep.
    for (int i = 0; i < 6; i++)
      run_block(HW0 + int'($urandom_range(0, 12)), 1'b0, 0, 0);

    // frame_start during a block restarts the order at the following block.
    run_block(HW0 + 2, 1'b0, 0, 0);
    run_block(HW0 + 5, 1'b0, 15, 0);
    run_block(HW0 + 1, 1'b0, 0, 0);
    run_block(HW0 + 1, 1'b0, 0, 0);

    // frame_start alone in IDLE.
    @(negedge clock);
    bus.frame_start = 1'b1;
    @(negedge clock);
    bus.frame_start = 1'b0;
    m_comp = 0;
    run_block(HW0 + 3, 1'b0, 0, 0);

    // frame_start coincident with the accept.
    run_block(HW0 + 4, 1'b1, 0, 0);

    for (int i = 0; i < 8; i++)
      run_block(HW0 + int'($urandom_range(0, 12)), 1'($urandom_range(0, 3) == 0),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, HW0)) : 0, 0);

`ifdef JPEG_SEQ_WDOG_EN
    run_block(0, 1'b0, 0, 0);
    run_block(HW0 + 2, 1'b0, 0, 0);
`endif

    // Reset on the first cycle of row 5, then a clean block afterwards.
    run_block(HW0 + 3, 1'b0, 0, Q0 + 5 * H);
    run_block(HW0 + 6, 1'b0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
